// File: rtl/fixed_div_seq.sv
// Sequential signed fixed-point divider: quotient = (a<<FRAC)/b, restoring radix-2, one bit per clock.
// Optional FIXED_DIV_ROUND_EN: extra guard iteration, quotient magnitude rounds half away from zero.
module fixed_div_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

`ifdef FIXED_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int N  = WIDTH + FRAC;
  localparam int NI = N + RND;
  localparam int MW = N + 1;
  localparam int IW = $clog2(NI + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           state_q, state_d;
  logic             sa_q, sa_d, sb_q, sb_d, bz_q, bz_d;
  logic [WIDTH-1:0] bmag_q, bmag_d;
  logic [NI-1:0]    dvd_q, dvd_d, mag_q, mag_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d, ov_q, ov_d;
  logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;

  // Operand magnitudes; 2^(WIDTH-1) is representable unsigned.
  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
  assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

  // Partial remainder stays below |b| <= 2^(WIDTH-1), so only the shifted trial needs WIDTH+1 bits.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             qbit;
  logic             unused_diff;
  assign shifted     = {rem_q, dvd_q[NI-1]};
  assign diff        = {1'b0, shifted} - {2'b00, bmag_q};
  assign qbit        = ~diff[WIDTH+1];
  assign unused_diff = diff[WIDTH];

  logic [MW-1:0]    mag_r, lim;
  logic [WIDTH-1:0] mag_lo, fix_q, fix_r;
  logic             neg, ovf;

  always_comb begin
`ifdef FIXED_DIV_ROUND_EN
    mag_r = (mag_q >> 1) + MW'(mag_q[0]);
`else
    mag_r = MW'(mag_q);
`endif
    neg    = sa_q ^ sb_q;
    lim    = neg ? (MW'(1) << (WIDTH-1)) : ((MW'(1) << (WIDTH-1)) - MW'(1));
    ovf    = mag_r > lim;
    mag_lo = mag_r[WIDTH-1:0];
    if (ovf)      fix_q = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else if (neg) fix_q = ~mag_lo + 1'b1;
    else          fix_q = mag_lo;
    fix_r = sa_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (b == '0) ? S_FIX : S_CALC;
      S_CALC:  if (iter_q == IW'(NI-1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sa_d   = sa_q;
    sb_d   = sb_q;
    bz_d   = bz_q;
    bmag_d = bmag_q;
    dvd_d  = dvd_q;
    mag_d  = mag_q;
    rem_d  = rem_q;
    iter_d = iter_q;
    busy_d = busy_q;
    done_d = 1'b0;
    dz_d   = dz_q;
    ov_d   = ov_q;
    quo_d  = quo_q;
    rmd_d  = rmd_q;
    case (state_q)
      S_IDLE: if (start) begin
        sa_d   = a[WIDTH-1];
        sb_d   = b[WIDTH-1];
        bz_d   = (b == '0);
        bmag_d = b_mag;
        dvd_d  = NI'(a_mag) << (FRAC + RND);
        mag_d  = '0;
        rem_d  = '0;
        iter_d = '0;
        busy_d = 1'b1;
      end
      S_CALC: begin
        dvd_d  = dvd_q << 1;
        mag_d  = {mag_q[NI-2:0], qbit};
        // The guard iteration must not disturb the truncated-quotient remainder.
        if (iter_q != IW'(N)) rem_d = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        iter_d = iter_q + 1'b1;
      end
      S_FIX: begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (bz_q) begin
          quo_d = '0;
          rmd_d = '0;
          dz_d  = 1'b1;
          ov_d  = 1'b0;
        end else begin
          quo_d = fix_q;
          rmd_d = fix_r;
          dz_d  = 1'b0;
          ov_d  = ovf;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      bz_q   <= 1'b0;
      bmag_q <= '0;
      dvd_q  <= '0;
      mag_q  <= '0;
      rem_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      ov_q   <= 1'b0;
      quo_q  <= '0;
      rmd_q  <= '0;
    end else begin
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      bz_q   <= bz_d;
      bmag_q <= bmag_d;
      dvd_q  <= dvd_d;
      mag_q  <= mag_d;
      rem_q  <= rem_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
      done_q <= done_d;
      dz_q   <= dz_d;
      ov_q   <= ov_d;
      quo_q  <= quo_d;
      rmd_q  <= rmd_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;

endmodule

// File: tb/tb_fixed_div_seq.sv
// Directed-vector bench for fixed_div_seq at Q16.16 defaults.
module tb_fixed_div_seq;
`ifdef FIXED_DIV_ROUND_EN
  localparam int LAT = 50;
  localparam bit RND = 1'b1;
`else
  localparam int LAT = 49;
  localparam bit RND = 1'b0;
`endif

  logic        clk, rst_n, start;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] quotient, remainder;
  int          n_chk, n_err;

  fixed_div_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input logic eov, input int elat);
    int lat;
    bit got;
    @(negedge clk);
    a = ta; b = tbv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    check({nm, "_busy"}, 64'(busy), 64'd1);
    lat = 0; got = 0;
    while (!got && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (done) got = 1;
    end
    check({nm, "_lat"}, 64'(lat), 64'(elat));
    check({nm, "_q"}, 64'(quotient), 64'(eq));
    check({nm, "_r"}, 64'(remainder), 64'(er));
    check({nm, "_dz"}, 64'(div_by_zero), 64'(edz));
    check({nm, "_ov"}, 64'(overflow), 64'(eov));
    check({nm, "_busy_lo"}, 64'(busy), 64'd0);
    @(posedge clk); #1;
    check({nm, "_done_pulse"}, 64'(done), 64'd0);
    check({nm, "_q_held"}, 64'(quotient), 64'(eq));
  endtask

  initial begin
    int dones, lat;
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_q", 64'(quotient), 64'd0);
    check("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op("six_by_two", 32'h0006_0000, 32'h0002_0000, 32'h0003_0000, 32'h0, 1'b0, 1'b0, LAT);
    run_op("neg_7p5", 32'hFFF8_8000, 32'h0002_0000, 32'hFFFC_4000, 32'h0, 1'b0, 1'b0, LAT);
    run_op("one_third", 32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 32'h0001_0000, 1'b0, 1'b0, LAT);
    // 2/3 = 0xAAAA.AA..: guard bit set, so rounding bumps the magnitude
    run_op("two_third", 32'h0002_0000, 32'h0003_0000, RND ? 32'h0000_AAAB : 32'h0000_AAAA,
           32'h0002_0000, 1'b0, 1'b0, LAT);
    run_op("neg_two_third", 32'hFFFE_0000, 32'h0003_0000, RND ? 32'hFFFF_5555 : 32'hFFFF_5556,
           32'hFFFE_0000, 1'b0, 1'b0, LAT);
    run_op("div_zero", 32'h0005_0000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1);
    run_op("ovf_pos", 32'h7FFF_0000, 32'h0000_0100, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, LAT);
    run_op("ovf_neg", 32'h7FFF_0000, 32'hFFFF_FF00, 32'h8000_0000, 32'h0, 1'b0, 1'b1, LAT);
    run_op("minneg_by_one", 32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 32'h0, 1'b0, 1'b0, LAT);
    run_op("minneg_by_m1", 32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, LAT);

    // start held through done: re-accepted on the edge after done
    @(negedge clk);
    a = 32'h0005_0000; b = 32'h0; start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_first_done", 64'(done), 64'd1);
    a = 32'h0006_0000; b = 32'h0002_0000;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_reaccept_busy", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_lat", 64'(lat), 64'(LAT));
    check("b2b_q", 64'(quotient), 64'h0003_0000);

    // start pulses while busy must be ignored
    @(negedge clk);
    a = 32'h0001_0000; b = 32'h0003_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int c = 0; c < 120; c++) begin
      if (c == 5 || c == 20) begin a = 32'h0009_0000; b = 32'h0; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      if (done) dones++;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_ign_dones", 64'(dones), 64'd1);
    check("busy_ign_q", 64'(quotient), 64'h0000_5555);
    check("busy_ign_dz", 64'(div_by_zero), 64'd0);

    // reset ten cycles into an operation aborts it
    @(negedge clk);
    a = 32'h7FFF_0000; b = 32'h0000_0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_q", 64'(quotient), 64'd0);
    check("abort_r", 64'(remainder), 64'd0);
    check("abort_flags", 64'({done, div_by_zero, overflow}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
